muon_lifetime_ctrl: RTL

- Measurement sequencer for the muon-lifetime datapath. It sits between the coincidence logic (single-cycle start/stop pulses) and the counter/display system.
- Arms on a start (muon arrival) pulse and times the interval to the stop (decay) pulse in prescaled ticks.
- Presents each result on a valid/ready interface, enforces a timeout window and a dead time, and keeps saturating decay/timeout event counts.

---
 rtl/muon_lifetime_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/muon_lifetime_ctrl.sv
// muon_lifetime_ctrl: start/stop lifetime sequencer with timeout, dead time and event counts; MUON_HOLDOFF_EN adds stop holdoff
module muon_lifetime_ctrl #(
  parameter int TICK_DIV = 10,
  parameter int WINDOW_TICKS = 200,
  parameter int DEAD_TICKS = 50,
  parameter int COUNT_W = 16,
  parameter int HOLDOFF_TICKS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic start_pulse,
  input  logic stop_pulse,
  input  logic clear_counts,
  output logic [COUNT_W-1:0] lifetime,
  output logic lifetime_valid,
  input  logic lifetime_ready,
  output logic [COUNT_W-1:0] decay_cnt,
  output logic [COUNT_W-1:0] timeout_cnt,
  output logic busy
);
  localparam int MAXT = (WINDOW_TICKS > DEAD_TICKS) ? WINDOW_TICKS : DEAD_TICKS;
  localparam int TW = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, MEASURE, REPORT, DEAD} state_t;
  state_t state;
  logic [PW-1:0] prescaler;
  logic [TW-1:0] tick_cnt;
  logic tick, stop_ok, timeout_hit, dead_done, inc_decay, inc_timeout;
  assign tick = prescaler == PW'(TICK_DIV - 1);
`ifdef MUON_HOLDOFF_EN
  assign stop_ok = stop_pulse && int'(tick_cnt) >= HOLDOFF_TICKS;
`else
  localparam int unused_holdoff = HOLDOFF_TICKS;
  assign stop_ok = stop_pulse;
`endif
  assign timeout_hit = state == MEASURE && tick && tick_cnt == TW'(WINDOW_TICKS - 1) && !stop_ok;
  assign dead_done = DEAD_TICKS == 0 || (tick && tick_cnt == TW'(DEAD_TICKS - 1));
  assign inc_decay = enable && state == REPORT && lifetime_ready;
  assign inc_timeout = enable && timeout_hit;
  // Sequencer: arm, time the interval, hand off the result, then sit out the dead time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prescaler <= '0;
      tick_cnt <= '0;
      lifetime <= '0;
      lifetime_valid <= 1'b0;
      busy <= 1'b0;
    end else if (!enable) begin
      state <= IDLE;
      lifetime_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_pulse) begin
          state <= MEASURE;
          prescaler <= '0;
          tick_cnt <= '0;
          busy <= 1'b1;
        end
        MEASURE: if (stop_ok) begin
          lifetime <= COUNT_W'(tick_cnt);
          lifetime_valid <= 1'b1;
          state <= REPORT;
        end else if (timeout_hit) begin
          state <= DEAD;
          prescaler <= '0;
          tick_cnt <= '0;
        end else begin
          prescaler <= tick ? '0 : prescaler + 1'b1;
          tick_cnt <= tick ? tick_cnt + 1'b1 : tick_cnt;
        end
        REPORT: if (lifetime_ready) begin
          lifetime_valid <= 1'b0;
          state <= DEAD;
          prescaler <= '0;
          tick_cnt <= '0;
        end
        DEAD: if (dead_done) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          prescaler <= tick ? '0 : prescaler + 1'b1;
          tick_cnt <= tick ? tick_cnt + 1'b1 : tick_cnt;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Saturating event counters; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decay_cnt <= '0;
      timeout_cnt <= '0;
    end else if (clear_counts) begin
      decay_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      decay_cnt <= (inc_decay && decay_cnt != '1) ? decay_cnt + 1'b1 : decay_cnt;
      timeout_cnt <= (inc_timeout && timeout_cnt != '1) ? timeout_cnt + 1'b1 : timeout_cnt;
    end
  end
endmodule
